// File: rtl/move_input_conditioner_pkg.sv
// Shared constants, FSM states and helpers for the move input conditioner.
// Imported by the debounce sub-module and the top.
package move_input_conditioner_pkg;

    localparam int DEF_DEBOUNCE_CYCLES      = 250000;
    localparam int DEF_REPEAT_DELAY_CYCLES  = 10000000;
    localparam int DEF_REPEAT_PERIOD_CYCLES = 3750000;

    localparam int CNT_W  = 18;
    localparam int TMR_W  = 24;
    localparam int NUM_SW = 4;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HOLD_DELAY = 2'd1,
        REPEAT     = 2'd2
    } state_t;

    // Keeps only the lowest set bit: Up > Down > Left > Right.
    function automatic logic [NUM_SW-1:0] first_set(input logic [NUM_SW-1:0] v);
        return v & (~v + NUM_SW'(1));
    endfunction

endpackage

// File: rtl/move_input_conditioner_switch_debounce.sv
// One switch: 2-FF synchroniser, debounce counter and press-edge pulse.
// Ports: CLK, RST (sync, active-high), raw in, stable level out, rise pulse out.
module move_input_conditioner_switch_debounce
    import move_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            cnt_q  <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            rise   <= 1'b0;
            if (sync_q[1] == stable) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // Accepted level change; rise marks only the press.
                stable <= ~stable;
                rise   <= ~stable;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/move_input_conditioner.sv
// Debounced, prioritised one-cycle move pulses from SW1..SW4 with hold-to-repeat.
// Ports: CLK, RST (sync, active-high), SW1..SW4 raw in, MOVE_* pulses, BTN_STATE.
// Optional: define AUTO_REPEAT_EN to build the HOLD_DELAY/REPEAT FSM and timer.
module move_input_conditioner
    import move_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    input  logic       SW4,
    output logic       MOVE_UP,
    output logic       MOVE_DOWN,
    output logic       MOVE_LEFT,
    output logic       MOVE_RIGHT,
    output logic [3:0] BTN_STATE
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << CNT_W) ||
        REPEAT_DELAY_CYCLES < 1 || REPEAT_DELAY_CYCLES > (1 << TMR_W) ||
        REPEAT_PERIOD_CYCLES < 1 || REPEAT_PERIOD_CYCLES > (1 << TMR_W))
    begin : g_bad_cfg
        $error("move_input_conditioner: cycle parameter out of range");
    end

    logic [NUM_SW-1:0] raw;
    logic [NUM_SW-1:0] stable;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] pulse_d;
    logic [NUM_SW-1:0] move_q;

    assign raw = {SW4, SW3, SW2, SW1};

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        move_input_conditioner_switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .CLK   (CLK),
            .RST   (RST),
            .raw   (raw[i]),
            .stable(stable[i]),
            .rise  (rise[i])
        );
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [NUM_SW-1:0] owner_q, owner_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              held;

    // Owner is one-hot, so it doubles as the repeat pulse pattern.
    assign held = |(stable & owner_q);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        timer_d = timer_q;
        pulse_d = '0;
        if (|rise) begin
            // A fresh press wins over release and same-cycle repeats.
            pulse_d = first_set(rise);
            owner_d = first_set(rise);
            timer_d = '0;
            state_d = HOLD_DELAY;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                HOLD_DELAY: begin
                    if (!held) begin
                        state_d = IDLE;
                    end else if (timer_q == DELAY_LAST) begin
                        pulse_d = owner_q;
                        timer_d = '0;
                        state_d = REPEAT;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                REPEAT: begin
                    if (!held) begin
                        state_d = IDLE;
                    end else if (timer_q == PERIOD_LAST) begin
                        pulse_d = owner_q;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
        end
    end
`else
    always_comb begin
        pulse_d = first_set(rise);
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            move_q <= '0;
        end else begin
            move_q <= pulse_d;
        end
    end

    assign MOVE_UP    = move_q[DIR_UP];
    assign MOVE_DOWN  = move_q[DIR_DOWN];
    assign MOVE_LEFT  = move_q[DIR_LEFT];
    assign MOVE_RIGHT = move_q[DIR_RIGHT];
    assign BTN_STATE  = stable;

endmodule
